// File: rtl/decode_word_packer_if.sv
// Bus bundle for decode_word_packer: the decoded byte stream in, the
// memory write port out, and the stream status outputs.
//
// Memory write handshake: mem_wr is the valid, mem_ack is the ready. A word
// transfers on a rising clk edge where mem_wr=1 and mem_ack=1. While
// mem_wr=1 and mem_ack=0, mem_addr/mem_wdata/mem_be are held stable.
// mem_ack is ignored while mem_wr=0.
interface decode_word_packer_if #(
  parameter int ADDR_W = 16
);
  logic              w_en;
  logic [7:0]        data;
  logic              done;
  logic              dict_error;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic              busy;
  logic              out_done;
  logic [1:0]        err;
  logic [ADDR_W+1:0] byte_count;

  // Upstream decoder plus memory side (drives stream and ack).
  modport master (
    output w_en, data, done, dict_error, mem_ack,
    input  mem_wr, mem_addr, mem_wdata, mem_be, busy, out_done, err, byte_count
  );

  // The packer itself.
  modport slave (
    input  w_en, data, done, dict_error, mem_ack,
    output mem_wr, mem_addr, mem_wdata, mem_be, busy, out_done, err, byte_count
  );
endinterface

// File: rtl/decode_word_packer.sv
// decode_word_packer: packs decoded bytes into 32-bit words, buffers them in
// a small FIFO and writes them out through a valid/ack memory port.
// Optional macro DECODE_PACK_BSWAP_EN selects big-endian lane order
// (lane 0 in bits [31:24]); little-endian lane order when undefined.
// state_dbg exposes the FSM state (0=ACCEPT, 1=DRAIN, 2=FIN).
module decode_word_packer #(
  parameter int              ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  decode_word_packer_if.slave     bus,
  output logic [1:0]              state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int PW    = PTR_W + 1;
  localparam int CNT_W = ADDR_W + 2;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    DRAIN  = 2'd1,
    FIN    = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Packing registers.
  logic [1:0]  lane_q;
  logic [31:0] word_q;

  // Word FIFO; pointers carry one extra wrap bit to tell full from empty.
  logic [31:0] fifo_data [FIFO_DEPTH];
  logic [3:0]  fifo_be   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic fifo_empty, fifo_full;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        err_q;
  logic [CNT_W-1:0]  count_q;
  logic              count_restart_q;

  logic        acc;
  logic [4:0]  shift;
  logic [31:0] byte_word;
  logic [31:0] merged;
  logic [2:0]  filled;
  logic        done_eff;
  logic        full_push;
  logic        part_push;
  logic        push;
  logic        pop;
  logic        overflow;
  logic [3:0]  push_be;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_full  = (rd_ptr[PTR_W] != wr_ptr[PTR_W]) &&
                      (rd_ptr[PTR_W-1:0] == wr_ptr[PTR_W-1:0]);

  // Byte lane placement and push decision for this cycle.
  always_comb begin
    acc = bus.w_en & ~bus.dict_error;
`ifdef DECODE_PACK_BSWAP_EN
    shift = 5'd24 - {lane_q, 3'b000};
`else
    shift = {lane_q, 3'b000};
`endif
    byte_word = {24'b0, bus.data} << shift;
    merged    = acc ? (word_q | byte_word) : word_q;
    filled    = {1'b0, lane_q} + {2'b00, acc};
    done_eff  = bus.done && (state_q == ACCEPT);
    full_push = acc && (lane_q == 2'd3);
    // A dictionary error discards the partial word, so there is nothing to flush.
    part_push = done_eff && !bus.dict_error && !full_push && (filled != 3'd0);
    push      = full_push | part_push;
    push_be   = 4'b1111;
    if (!full_push) begin
      case (filled)
`ifdef DECODE_PACK_BSWAP_EN
        3'd1:    push_be = 4'b1000;
        3'd2:    push_be = 4'b1100;
        3'd3:    push_be = 4'b1110;
`else
        3'd1:    push_be = 4'b0001;
        3'd2:    push_be = 4'b0011;
        3'd3:    push_be = 4'b0111;
`endif
        default: push_be = 4'b1111;
      endcase
    end
    pop      = !fifo_empty && bus.mem_ack;
    // A full FIFO can still take a word in the cycle its head is accepted.
    overflow = push && fifo_full && !pop;
  end

  // Lane counter and partial-word accumulator.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      lane_q <= 2'd0;
      word_q <= 32'd0;
    end else if (bus.dict_error || push) begin
      lane_q <= 2'd0;
      word_q <= 32'd0;
    end else if (acc) begin
      lane_q <= lane_q + 2'd1;
      word_q <= merged;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (push && !overflow) begin
      fifo_data[wr_ptr[PTR_W-1:0]] <= merged;
      fifo_be[wr_ptr[PTR_W-1:0]]   <= push_be;
    end
  end

  // FIFO pointers and the write address, which follows the FIFO head.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      addr_q <= BASE_ADDR;
    end else begin
      if (push && !overflow) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  // Sticky error flags and the per-stream byte counter.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      err_q           <= 2'b00;
      count_q         <= '0;
      count_restart_q <= 1'b0;
    end else begin
      if (bus.dict_error) err_q[0] <= 1'b1;
      if (overflow)       err_q[1] <= 1'b1;
      if (acc) begin
        count_q         <= (count_restart_q || state_q == FIN) ? CNT_W'(1)
                                                               : count_q + CNT_W'(1);
        count_restart_q <= 1'b0;
      end else if (state_q == FIN) begin
        count_restart_q <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= ACCEPT;
    else        state_q <= state_d;
  end

  // FSM next state: wait for done, drain the FIFO, pulse completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCEPT:  if (bus.done) state_d = DRAIN;
      DRAIN:   if (fifo_empty) state_d = FIN;
      FIN:     state_d = ACCEPT;
      default: state_d = ACCEPT;
    endcase
  end

  assign bus.mem_wr     = !fifo_empty;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = fifo_data[rd_ptr[PTR_W-1:0]];
  assign bus.mem_be     = fifo_be[rd_ptr[PTR_W-1:0]];
  assign bus.busy       = !fifo_empty || (lane_q != 2'd0) || (state_q == DRAIN);
  assign bus.out_done   = (state_q == FIN);
  assign bus.err        = err_q;
  assign bus.byte_count = count_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_decode_word_packer.sv
// Directed bench for decode_word_packer: drives byte streams through the
// interface, checks every memory write against an expected queue and
// checks status outputs against hand-computed values.
module tb_decode_word_packer;

  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] BASE = 16'h0010;
  localparam int W = ADDR_W + 4 + 32;

  logic clk;
  logic n_rst;
  logic [1:0] state_dbg;

  decode_word_packer_if #(.ADDR_W(ADDR_W)) bus ();

  decode_word_packer #(
    .ADDR_W(ADDR_W),
    .BASE_ADDR(BASE),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int od_count = 0;
  logic [W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted write must match the head of exp_q.
  always @(negedge clk) begin
    if (n_rst && bus.out_done) od_count++;
    if (n_rst && bus.mem_wr && bus.mem_ack) begin
      if (exp_q.size() == 0) check("unexpected_write", 64'(bus.mem_wdata), 64'hdead);
      else check("write", 64'({bus.mem_addr, bus.mem_be, bus.mem_wdata}), 64'(exp_q.pop_front()));
    end
  end

  // Driver tasks; all start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    bus.w_en = 1'b1;
    bus.data = b;
    bus.done = d;
    tick();
    bus.w_en = 1'b0;
    bus.done = 1'b0;
  endtask

  task automatic send_done();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] be);
    exp_q.push_back({exp_addr, be, d});
    exp_addr = exp_addr + 16'd1;
  endtask

  task automatic wait_out_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.out_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 64'(seen), 64'd1);
    tick();
  endtask

  initial begin
    int od_before;
    logic [31:0] head;
    n_rst = 1'b0;
    bus.w_en = 1'b0;
    bus.data = 8'h00;
    bus.done = 1'b0;
    bus.dict_error = 1'b0;
    bus.mem_ack = 1'b1;
    exp_addr = BASE;
    repeat (3) tick();

    // Reset values.
    @(negedge clk);
    check("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'(BASE));
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_byte_count", 64'(bus.byte_count), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_out_done", 64'(bus.out_done), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    tick();
    n_rst = 1'b1;
    tick();

    // One full word with ack held high.
    expect_word(32'h44332211, 4'b1111);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    check("t1_addr", 64'(bus.mem_addr), 64'(BASE + 16'd1));
    check("t1_count", 64'(bus.byte_count), 64'd4);
    tick();
    send_done();
    wait_out_done("t1_out_done");

    // done coincident with the fourth byte, then a 5-byte stream.
    expect_word(32'hDDCCBBAA, 4'b1111);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b1);
    wait_out_done("t2a_out_done");
    od_before = od_count;
    expect_word(32'h04030201, 4'b1111);
    expect_word(32'h00000005, 4'b0001);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
    send_done();
    wait_out_done("t2b_out_done");
    repeat (4) tick();
    check("t2_out_done_once", 64'(od_count - od_before), 64'd1);
    @(negedge clk);
    check("t2_count", 64'(bus.byte_count), 64'd5);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
    tick();

    // done with nothing buffered: out_done exactly two cycles later.
    send_done();
    @(negedge clk);
    check("t3_od_c1", 64'(bus.out_done), 64'd0);
    @(negedge clk);
    check("t3_od_c2", 64'(bus.out_done), 64'd1);
    @(negedge clk);
    check("t3_od_c3", 64'(bus.out_done), 64'd0);
    check("t3_busy", 64'(bus.busy), 64'd0);
    tick();

    // Overflow: ack held low while 20 bytes (5 words) arrive.
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 20; i++) send_byte(8'h10 + 8'(i), 1'b0);
    @(negedge clk);
    check("t4_err", 64'(bus.err), 64'b10);
    check("t4_mem_wr", 64'(bus.mem_wr), 64'd1);
    check("t4_wdata", 64'(bus.mem_wdata), 64'h13121110);
    check("t4_be", 64'(bus.mem_be), 64'hF);
    check("t4_addr", 64'(bus.mem_addr), 64'(exp_addr));
    check("t4_count", 64'(bus.byte_count), 64'd20);
    check("t4_busy", 64'(bus.busy), 64'd1);
    head = 32'h13121110;
    repeat (5) @(negedge clk);
    check("t4_wdata_hold", 64'(bus.mem_wdata), 64'(head));
    check("t4_mem_wr_hold", 64'(bus.mem_wr), 64'd1);
    tick();

    // Reset while a write is pending.
    n_rst = 1'b0;
    tick();
    @(negedge clk);
    check("t5_mem_wr", 64'(bus.mem_wr), 64'd0);
    check("t5_addr", 64'(bus.mem_addr), 64'(BASE));
    check("t5_err", 64'(bus.err), 64'd0);
    check("t5_count", 64'(bus.byte_count), 64'd0);
    exp_q.delete();
    exp_addr = BASE;
    tick();
    n_rst = 1'b1;
    bus.mem_ack = 1'b1;
    tick();

    // Dictionary error discards the partial word and ignores its bytes.
    expect_word(32'h06050403, 4'b1111);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    bus.dict_error = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(8'hFF, 1'b0);
    bus.dict_error = 1'b0;
    for (int i = 3; i <= 6; i++) send_byte(8'(i), 1'b0);
    send_done();
    wait_out_done("t6_out_done");
    @(negedge clk);
    check("t6_err", 64'(bus.err), 64'b01);
    check("t6_count", 64'(bus.byte_count), 64'd6);
    check("t6_addr", 64'(bus.mem_addr), 64'(BASE + 16'd1));
    check("t6_busy", 64'(bus.busy), 64'd0);
    tick();

    repeat (3) tick();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
